// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: raster timing generator and pixel formatter for a parallel
// RGB LCD panel.
//   pixel_clk            sole clock, rising edge
//   rst_n                synchronous active-low reset (overrides en)
//   en                   run enable; low freezes counters, pipeline and outputs
//   mode[1:0]            0 pix_in, 1 checker, 2 colour bars, 3 solid white
//   pix_in               upstream mono pixel, arrives PIPE_DELAY cycles after x/y
//   x, y, fetch          combinational active-area coordinates (0 when blanking)
//   line_start           h_cnt==0 pulse; frame_start: h_cnt==0 and v_cnt==0
//   de, hsync_n, vsync_n registered panel controls, PIPE_DELAY+1 cycles late
//   red, green, blue     registered colour channels, zero whenever de is low
module lcd_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_BLANK    = 160,
  parameter int V_ACTIVE   = 480,
  parameter int V_BLANK    = 45,
  parameter int HS_WIDTH   = 96,
  parameter int VS_WIDTH   = 2,
  parameter int PIPE_DELAY = 2,
  parameter int CW         = 8,
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic          pixel_clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic          pix_in,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          fetch,
  output logic          line_start,
  output logic          frame_start,
  output logic          de,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic [CW-1:0] red,
  output logic [CW-1:0] green,
  output logic [CW-1:0] blue
);
  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
  localparam int PW      = 9;
  // Delay-line word: {fetch, hsync_n, vsync_n, mode[1:0], checker, bar[2:0]}
  localparam logic [PW-1:0] IDLE_WORD = 9'b011_00_0_000;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [31:0]   h_ext_s, v_ext_s, bar_ext_s;
  logic          hs_low_s, vs_low_s, chk_s;
  logic [2:0]    bar_s;
  logic [1:0]    mode_eff_s;
  logic [PW-1:0] entry_s;
  logic [PW-1:0] tap_s [PIPE_DELAY+1];

  assign h_ext_s     = 32'(h_cnt_q);
  assign v_ext_s     = 32'(v_cnt_q);
  assign fetch       = (h_ext_s < 32'(H_ACTIVE)) && (v_ext_s < 32'(V_ACTIVE));
  assign x           = fetch ? XW'(h_cnt_q) : '0;
  assign y           = fetch ? YW'(v_cnt_q) : '0;
  assign line_start  = (h_cnt_q == '0);
  assign frame_start = line_start && (v_cnt_q == '0);

  assign hs_low_s  = (h_ext_s >= 32'(H_ACTIVE)) && (h_ext_s < 32'(H_ACTIVE + HS_WIDTH));
  assign vs_low_s  = (v_ext_s >= 32'(V_ACTIVE)) && (v_ext_s < 32'(V_ACTIVE + VS_WIDTH));
  assign chk_s     = h_ext_s[4] ^ v_ext_s[4];
  assign bar_ext_s = h_ext_s / 32'(BAR_W);
  assign bar_s     = (bar_ext_s > 32'd7) ? 3'd7 : bar_ext_s[2:0];
  // The first pixel of a frame already uses the mode being latched on that cycle.
  assign mode_eff_s = frame_start ? mode : mode_q;
  assign entry_s    = {fetch, ~hs_low_s, ~vs_low_s, mode_eff_s, chk_s, bar_s};

  // Next-state logic for the raster counters and the per-frame mode latch.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    mode_d  = mode_q;
    if (en) begin
      if (frame_start) begin
        mode_d = mode;
      end else begin
        mode_d = mode_q;
      end
      if (h_ext_s == 32'(H_TOTAL - 1)) begin
        h_cnt_d = '0;
        if (v_ext_s == 32'(V_TOTAL - 1)) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + VW'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end else begin
      h_cnt_d = h_cnt_q;
    end
  end

  // Counter and mode registers.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      mode_q  <= 2'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Delay line that aligns timing/control words with the upstream pixel.
  assign tap_s[0] = entry_s;
  for (genvar i = 1; i <= PIPE_DELAY; i++) begin : g_pipe
    logic [PW-1:0] stage_q;
    // One delay stage, frozen while en is low.
    always_ff @(posedge pixel_clk) begin
      if (!rst_n) begin
        stage_q <= IDLE_WORD;
      end else if (en) begin
        stage_q <= tap_s[i-1];
      end else begin
        stage_q <= stage_q;
      end
    end
    assign tap_s[i] = stage_q;
  end

  logic [PW-1:0] out_w_s;
  logic          r_on_s, g_on_s, b_on_s;
  assign out_w_s = tap_s[PIPE_DELAY];

  // Colour source selection for the aligned word.
  always_comb begin
    r_on_s = 1'b0;
    g_on_s = 1'b0;
    b_on_s = 1'b0;
    if (out_w_s[8]) begin
      case (out_w_s[5:4])
        2'd0:    begin r_on_s = pix_in;      g_on_s = pix_in;      b_on_s = pix_in;      end
        2'd1:    begin r_on_s = out_w_s[3];  g_on_s = out_w_s[3];  b_on_s = out_w_s[3];  end
        2'd2:    begin r_on_s = out_w_s[2];  g_on_s = out_w_s[1];  b_on_s = out_w_s[0];  end
        2'd3:    begin r_on_s = 1'b1;        g_on_s = 1'b1;        b_on_s = 1'b1;        end
        default: begin r_on_s = 1'b0;        g_on_s = 1'b0;        b_on_s = 1'b0;        end
      endcase
    end else begin
      r_on_s = 1'b0;
    end
  end

  logic          de_q, hs_q, vs_q;
  logic [CW-1:0] red_q, green_q, blue_q;

  // Panel output register stage.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      de_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (en) begin
      de_q    <= out_w_s[8];
      hs_q    <= out_w_s[7];
      vs_q    <= out_w_s[6];
      red_q   <= {CW{r_on_s}};
      green_q <= {CW{g_on_s}};
      blue_q  <= {CW{b_on_s}};
    end else begin
      de_q    <= de_q;
      hs_q    <= hs_q;
      vs_q    <= vs_q;
      red_q   <= red_q;
      green_q <= green_q;
      blue_q  <= blue_q;
    end
  end

  assign de      = de_q;
  assign hsync_n = hs_q;
  assign vsync_n = vs_q;
  assign red     = red_q;
  assign green   = green_q;
  assign blue    = blue_q;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Testbench for lcd_timing_gen with a reduced 64x40 raster (80x45 total).
module tb_lcd_timing_gen;
  localparam int HA = 64, HB = 16, VA = 40, VB = 5, HSW = 8, VSW = 2, PD = 2;
  localparam int HT = HA + HB, VT = VA + VB, FRAME = HT * VT;

  typedef struct packed {
    logic       de, hs, vs;
    logic [7:0] r, g, b;
  } out_t;
  typedef struct packed {
    logic       f;
    logic [5:0] x, y;
    logic       ls, fs;
  } ctl_t;

  localparam out_t IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, r: 8'h00, g: 8'h00, b: 8'h00};

  logic clk = 1'b0;
  logic rst_n = 1'b0, en = 1'b0, pix_in = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [5:0] x_o, y_o;
  logic fetch_o, ls_o, fs_o, de_o, hs_o, vs_o;
  logic [7:0] r_o, g_o, b_o;

  lcd_timing_gen #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
                   .HS_WIDTH(HSW), .VS_WIDTH(VSW), .PIPE_DELAY(PD), .CW(8)) dut (
    .pixel_clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .pix_in(pix_in),
    .x(x_o), .y(y_o), .fetch(fetch_o), .line_start(ls_o), .frame_start(fs_o),
    .de(de_o), .hsync_n(hs_o), .vsync_n(vs_o), .red(r_o), .green(g_o), .blue(b_o));

  always #5 clk = ~clk;

  int   n_checks = 0, n_pass = 0;
  out_t sb[$];
  ctl_t cq[$];
  logic ph[$];
  int   hm = 0, vm = 0;
  logic [1:0] mm = 2'd0;
  logic go = 1'b0;
  int   de_cnt = 0, hs_cnt = 0, vs_cnt = 0, white_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  // Expected panel word for raster position (h,v) under mode m.
  function automatic out_t expect_out(input int h, input int v, input logic [1:0] m);
    out_t o;
    int   bar;
    logic on_r, on_g, on_b;
    o.de = (h < HA) && (v < VA);
    o.hs = !((h >= HA) && (h < HA + HSW));
    o.vs = !((v >= VA) && (v < VA + VSW));
    bar  = h / 8;
    case (m)
      2'd0:    begin on_r = (h == 5); on_g = on_r; on_b = on_r; end
      2'd1:    begin on_r = (((h >> 4) ^ (v >> 4)) & 1) == 1; on_g = on_r; on_b = on_r; end
      2'd2:    begin on_r = (bar & 4) != 0; on_g = (bar & 2) != 0; on_b = (bar & 1) != 0; end
      default: begin on_r = 1'b1; on_g = 1'b1; on_b = 1'b1; end
    endcase
    o.r = (o.de && on_r) ? 8'hff : 8'h00;
    o.g = (o.de && on_g) ? 8'hff : 8'h00;
    o.b = (o.de && on_b) ? 8'hff : 8'h00;
    return o;
  endfunction

  function automatic ctl_t expect_ctl(input int h, input int v);
    ctl_t c;
    c.f  = (h < HA) && (v < VA);
    c.x  = c.f ? 6'(h) : 6'd0;
    c.y  = c.f ? 6'(v) : 6'd0;
    c.ls = (h == 0);
    c.fs = (h == 0) && (v == 0);
    return c;
  endfunction

  // One clock of stimulus; expectations for that edge go to the scoreboards.
  task automatic step(input logic r, input logic e);
    logic [1:0] meff;
    @(negedge clk);
    rst_n = r;
    en    = e;
    go    = 1'b1;
    if (!r) begin
      sb.delete();
      ph.delete();
      for (int i = 0; i < PD; i++) begin
        sb.push_back(IDLE);
        ph.push_back(1'b0);
      end
      pix_in = 1'b0;
      hm = 0; vm = 0; mm = 2'd0;
    end else if (e) begin
      meff = (hm == 0 && vm == 0) ? mode : mm;
      sb.push_back(expect_out(hm, vm, meff));
      ph.push_back((hm == 5) && (hm < HA) && (vm < VA));
      pix_in = ph.pop_front();
      if (hm == 0 && vm == 0) mm = mode;
      if (hm == HT - 1) begin
        hm = 0;
        vm = (vm == VT - 1) ? 0 : vm + 1;
      end else begin
        hm = hm + 1;
      end
    end
    cq.push_back(expect_ctl(hm, vm));
  endtask

  task automatic run_steps(input int n, input int hold_at, input int hold_len);
    for (int i = 0; i < n; i++) begin
      if (i == hold_at) begin
        for (int k = 0; k < hold_len; k++) step(1'b1, 1'b0);
      end
      step(1'b1, 1'b1);
    end
  endtask

  task automatic clear_counts();
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; white_cnt = 0;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares every edge's outputs against the scoreboard queues.
  initial begin : monitor
    out_t exp_o, last_o, act_o;
    ctl_t exp_c, act_c;
    logic r_s, e_s;
    last_o = IDLE;
    forever begin
      @(posedge clk);
      r_s = rst_n;
      e_s = en;
      #1;
      if (go) begin
        if (!r_s) begin
          exp_o = IDLE;
        end else if (e_s) begin
          if (sb.size() == 0) begin
            $display("FAIL sb_empty: got 0 entries expected >0");
            n_checks++;
            exp_o = last_o;
          end else begin
            exp_o = sb.pop_front();
          end
        end else begin
          exp_o = last_o;
        end
        act_o = '{de: de_o, hs: hs_o, vs: vs_o, r: r_o, g: g_o, b: b_o};
        chk("panel_out", 64'(act_o), 64'(exp_o));
        last_o = exp_o;
        if (r_s && e_s) begin
          if (de_o) de_cnt++;
          if (!hs_o) hs_cnt++;
          if (!vs_o) vs_cnt++;
          if (r_o == 8'hff && g_o == 8'hff && b_o == 8'hff) white_cnt++;
        end
        if (cq.size() == 0) begin
          $display("FAIL cq_empty: got 0 entries expected >0");
          n_checks++;
        end else begin
          exp_c = cq.pop_front();
          act_c = '{f: fetch_o, x: x_o, y: y_o, ls: ls_o, fs: fs_o};
          chk("counter_ctl", 64'(act_c), 64'(exp_c));
        end
      end
    end
  end

  initial begin : stimulus
    mode = 2'd0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    settle();
    chk("reset_frame_start", 64'(fs_o), 64'd1);
    chk("reset_de", 64'(de_o), 64'd0);

    // Frame 1: upstream pixel lit only at column 5.
    clear_counts();
    run_steps(FRAME, -1, 0);
    settle();
    chk("f1_de_count", 64'(de_cnt), 64'd2560);
    chk("f1_hsync_low", 64'(hs_cnt), 64'd360);
    chk("f1_vsync_low", 64'(vs_cnt), 64'd160);
    chk("f1_pix_white", 64'(white_cnt), 64'd40);

    // Frame 2: colour bars, one white bar of 8 columns.
    mode = 2'd2;
    clear_counts();
    run_steps(FRAME, -1, 0);
    settle();
    chk("f2_bar_white", 64'(white_cnt), 64'd320);
    chk("f2_de_count", 64'(de_cnt), 64'd2560);

    // Frame 3: checker, switched to white at row 10; stays checker.
    mode = 2'd1;
    clear_counts();
    run_steps(10 * HT, -1, 0);
    mode = 2'd3;
    run_steps(FRAME - 10 * HT, -1, 0);
    settle();
    chk("f3_checker_white", 64'(white_cnt), 64'd1280);

    // Frame 4: white from first pixel, with a 17-cycle enable gap at row 3 col 30.
    clear_counts();
    run_steps(FRAME, 3 * HT + 30, 17);
    settle();
    chk("f4_white", 64'(white_cnt), 64'd2560);
    chk("f4_de_count", 64'(de_cnt), 64'd2560);

    // Frame 5: reset pulse at row 20 with en held high.
    run_steps(20 * HT, -1, 0);
    step(1'b0, 1'b1);
    settle();
    chk("midreset_frame_start", 64'(fs_o), 64'd1);
    chk("midreset_hsync", 64'(hs_o), 64'd1);
    run_steps(300, -1, 0);
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
